// File: rtl/mod6_bcd_pkg.sv
// Shared timer definitions: BCD digit type and per-stage digit limits.
// Pure declarations; no logic, no latency, no flow control.
package mod6_bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam int SEC_TENS_MAX = 5;
  localparam int DIGIT_MAX    = 9;

endpackage

// File: rtl/bcd_digit_next.sv
// Next-value logic for one BCD down-counting digit: saturating load, decrement, wrap to MAX_DIGIT.
// Combinational, zero latency; no backpressure (pure function of its inputs).
module bcd_digit_next
  import mod6_bcd_pkg::*;
#(
  parameter int MAX_DIGIT = SEC_TENS_MAX
) (
  input  logic [3:0] cur,
  input  logic       load,
  input  logic       dec,
  input  logic [3:0] data,
  output logic [3:0] nxt
);

  localparam bcd_t MAXV = bcd_t'(MAX_DIGIT);

  always_comb begin
    nxt = cur;
    if (load) begin
      nxt = (data > MAXV) ? MAXV : data;
    end else if (dec) begin
      // An out-of-range current value is pulled back to MAXV rather than decremented.
      if (cur == 4'd0 || cur > MAXV) begin
        nxt = MAXV;
      end else begin
        nxt = cur - 4'd1;
      end
    end
  end

endmodule

// File: rtl/mod6_bcd.sv
// Tens-of-seconds BCD down-counter (MAX_DIGIT..0) with borrow (tc) and zero flag.
// Digit updates one cycle after clr/load/en; tc and zero are combinational; no backpressure.
module mod6_bcd
  import mod6_bcd_pkg::*;
#(
  parameter int MAX_DIGIT = SEC_TENS_MAX
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       loadn,
  input  logic       en,
  input  logic [3:0] data,
  output logic [3:0] tens,
  output logic       tc,
  output logic       zero
);

  bcd_t nxt;
  logic load;

  // Only an explicit 0 loads, so an undriven loadn cannot disturb a cleared digit.
  assign load = (loadn == 1'b0);

  bcd_digit_next #(
    .MAX_DIGIT(MAX_DIGIT)
  ) u_next (
    .cur (tens),
    .load(load),
    .dec (en),
    .data(data),
    .nxt (nxt)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      tens <= '0;
    end else begin
      tens <= nxt;
    end
  end

  assign zero = (tens == 4'd0);
  assign tc   = en & zero;

endmodule

// File: tb/tb_mod6_bcd.sv
// Scoreboard bench for mod6_bcd: expected digits queued at drive time, popped after each edge.
// Combinational tc/zero are checked against the model just before each edge.
module tb_mod6_bcd;

  logic       clk;
  logic       clr;
  logic       loadn;
  logic       en;
  logic [3:0] data;
  logic [3:0] tens;
  logic       tc;
  logic       zero;

  int n_vec;
  int n_err;

  logic [3:0] exp_q[$];
  logic [3:0] model;
  logic       model_vld;

  mod6_bcd #(.MAX_DIGIT(5)) dut (
    .clk  (clk),
    .clr  (clr),
    .loadn(loadn),
    .en   (en),
    .data (data),
    .tens (tens),
    .tc   (tc),
    .zero (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // One clock of stimulus: check pre-edge flags, queue the post-edge digit, then compare it.
  task automatic step(input logic c, input logic ln, input logic e, input logic [3:0] d);
    logic [3:0] nxt;
    @(negedge clk);
    clr   = c;
    loadn = ln;
    en    = e;
    data  = d;
    #1;
    if (model_vld) begin
      chk("zero", {3'b0, zero}, {3'b0, (model == 4'd0)});
      chk("tc",   {3'b0, tc},   {3'b0, (e && model == 4'd0)});
    end
    if (c) begin
      nxt = 4'd0;
    end else if (ln === 1'b0) begin
      nxt = (d > 4'd5) ? 4'd5 : d;
    end else if (e) begin
      nxt = (model == 4'd0) ? 4'd5 : model - 4'd1;
    end else begin
      nxt = model;
    end
    exp_q.push_back(nxt);
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      chk("queue", 4'hF, 4'h0);
    end else begin
      chk("tens", tens, exp_q.pop_front());
    end
    if (c || model_vld) begin
      model     = nxt;
      model_vld = 1'b1;
    end
  endtask

  initial begin
    n_vec     = 0;
    n_err     = 0;
    model     = 4'd0;
    model_vld = 1'b0;

    // Clear with loadn and data left undriven.
    for (int i = 0; i < 5; i++) step(1'b1, 1'bx, 1'b1, 4'bxxxx);
    step(1'b1, 1'b1, 1'b0, 4'd0);

    // Load 5 and hold for 9 idle cycles.
    step(1'b0, 1'b0, 1'b0, 4'd5);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 1'b0, 4'd0);

    // Count down through two wraps.
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 1'b1, 4'd0);

    // Load saturation and an in-range load.
    step(1'b0, 1'b0, 1'b0, 4'd9);
    step(1'b0, 1'b0, 1'b0, 4'd15);
    step(1'b0, 1'b0, 1'b0, 4'd3);

    // Priority: clear beats load and enable; then load beats enable.
    step(1'b1, 1'b0, 1'b1, 4'd4);
    step(1'b0, 1'b0, 1'b1, 4'd4);

    // Hold at 2 for 10 cycles.
    step(1'b0, 1'b0, 1'b0, 4'd2);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0, 4'd0);

    // Random mix of clear, load and enable.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) == 0), ($urandom_range(0, 5) != 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mod6_bcd.md
Name: mod6_bcd

Overview:
- Single-digit BCD down-counter, modulus 6 (values 5..0). Holds the tens-of-seconds digit of the microwave timer.
- It is loaded from the keypad/setting path and decremented once per enable pulse from the ones-of-seconds stage.
- It produces a borrow/terminal-count output for the next (minutes) stage, and a zero flag for end-of-time detection.

Parameters:
- MAX_DIGIT, default 5: highest digit value; the counter wraps from 0 to MAX_DIGIT. Legal range is 1..9.

Ports:
- clk: input, 1 bit. Single clock; all state changes on the rising edge.
- clr: input, 1 bit. Synchronous, active-high reset/clear.
- loadn: input, 1 bit. Synchronous, active-low parallel load.
- en: input, 1 bit. Count enable, active-high. Decrements the digit by one per enabled cycle.
- data: input, 4 bits. BCD digit to load.
- tens: output, 4 bits. Current BCD digit (registered).
- tc: output, 1 bit. Terminal count / borrow to the next stage (combinational).
- zero: output, 1 bit. High when the digit equals 0 (combinational from register).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high (clr). The polarity and synchronicity are fixed.
- Reset: when clr=1 at a rising edge, tens becomes 0. Consequently zero=1, and tc=en.
- Priority at each rising edge:
  - clr=1 is highest.
  - Otherwise loadn=0 loads data.
  - Otherwise en=1 decrements.
  - Otherwise the counter holds.
- Load:
  - data 0..MAX_DIGIT is loaded as-is.
  - data > MAX_DIGIT (including non-BCD 10..15) is saturated to MAX_DIGIT.
  - Load ignores en.
- Decrement:
  - tens goes to tens-1 for tens in 1..MAX_DIGIT.
  - tens=0 wraps to MAX_DIGIT.
  - Latency is one cycle; the new value is visible after the edge.
- tc = en AND (tens == 0). It is asserted in the same cycle the wrap will occur, to decrement the next stage, and is independent of loadn and clr.
- zero = (tens == 0), regardless of en.
- Unknown or undriven loadn before first use must not corrupt state once clr has been applied. Implementations treat loadn as 1 unless it is explicitly 0 (use a ==1'b0 compare).
- The register never holds a value > MAX_DIGIT under any input sequence.
- Clear asserted mid-count or during a load: the clear wins and tens=0 on that edge.
- Simultaneous loadn=0 and en=1: the load wins and no decrement occurs on that edge. tc still reflects the pre-edge value.

Decomposition:
- Shared timer package holds:
  - the BCD digit typedef (4-bit logic);
  - constants for digit limits (SEC_TENS_MAX=5, DIGIT_MAX=9) reused by the mod-10 and mod-6 stages.
- A single sub-module is natural: bcd_digit_next, a combinational next-value function handling load saturation, decrement, and wrap.
  - It is shared with the mod-10 seconds/minutes digits via MAX_DIGIT.
  - The top module holds the register and the tc/zero logic.

Test Plan:
- Reset: clr=1, en=1 for 5 cycles -> tens=0, zero=1, tc=1 each cycle. With en=0 -> tc=0.
- Load: clr=0, en=0, loadn=0 with data=5 for one cycle, then loadn=1 -> tens=5, zero=0, tc=0. The value is held for 9 idle cycles.
- Count-down wrap: from 5 with en=1 for 15 cycles -> sequence 4,3,2,1,0,5,4,3,2,1,0,5,4,3,2.
  - tc=1 exactly in the cycles where tens=0.
  - zero mirrors tens==0.
- Load saturation: loadn=0 with data=9, then data=15 -> tens=5 both times. With data=3 -> tens=3.
- Priority: at tens=3, assert clr=1, loadn=0 (data=4), and en=1 together -> tens=0.
  - Next cycle: clr=0, loadn=0 (data=4), en=1 -> tens=4, with no decrement.
- Hold: en=0, loadn=1, clr=0 for 10 cycles at tens=2 -> tens stays 2, tc=0, zero=0.
